// File: rtl/qpsk_pkg.sv
// Shared constants and helpers for the QPSK symbol framer.
package qpsk_pkg;
  localparam logic MODE_SOFT = 1'b0;
  localparam logic MODE_HARD = 1'b1;
  localparam int SYMS_PER_WORD = 16;
  localparam int PACK_W = 2 * SYMS_PER_WORD;

  // Hard decision: sign bit of each component, 1 = negative.
  function automatic logic [1:0] hard_bits(input logic i_msb, input logic q_msb);
    return {i_msb, q_msb};
  endfunction
endpackage

// File: rtl/qpsk_sym_fifo.sv
// Beat FIFO with a registered first-word-fall-through output stage.
// The output register counts toward capacity, so total occupancy never exceeds 2^AW.
module qpsk_sym_fifo #(
  parameter int W  = 33,
  parameter int AW = 5
) (
  input  logic          ce_clk,
  input  logic          ce_rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, mem_cnt;
  logic         wr, pop, load;

  assign full    = (level == DEPTH_L);
  assign wr      = wr_en & ~full;
  assign pop     = rd_valid & rd_ready;
  assign mem_cnt = wr_ptr - rd_ptr;
  // A word written this cycle is not visible to the output stage until the next one.
  assign load    = (mem_cnt != '0) & (~rd_valid | pop);

  always_ff @(posedge ce_clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rd_data  <= mem[rd_ptr[AW-1:0]];
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/qpsk_symbol_framer.sv
// Symbol-rate framer: captures strobed IQ beats, optionally packs hard decisions,
// re-frames to cfg_spp beats per packet and buffers the result without upstream stall.
module qpsk_symbol_framer
  import qpsk_pkg::*;
#(
  parameter int IQ_W    = 16,
  parameter int FIFO_AW = 5,
  parameter int SPP_W   = 12
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic [2*IQ_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 sym_stb,
  input  logic                 cfg_mode,
  input  logic [SPP_W-1:0]     cfg_spp,
  input  logic                 cfg_flush,
  output logic [2*IQ_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [15:0]          overflow_cnt,
  output logic [FIFO_AW:0]     fifo_level
);
  localparam int DW   = 2 * IQ_W;
  localparam int PC_W = $clog2(SYMS_PER_WORD);
  localparam logic [PC_W-1:0] LAST_SYM = PC_W'(SYMS_PER_WORD - 1);

  logic             sym, closed, mode_eff, hard, flush_go, word_done;
  logic             mode_q;
  logic [SPP_W-1:0] spp_q, spp_eff, spp_lim, beat_cnt;
  logic [PC_W-1:0]  pack_cnt;
  logic [PC_W:0]    pack_pos;
  logic [PACK_W-1:0] pack_q, pack_nxt;
  logic             form, form_last;
  logic [DW-1:0]    form_data;
  logic             beat_vld, beat_last;
  logic [DW-1:0]    beat_data;
  logic             fifo_full;

  assign s_axis_tready = ~ce_rst;
  assign sym      = s_axis_tvalid & sym_stb;
  assign closed   = (beat_cnt == '0) && (pack_cnt == '0);
  // While no packet is open the live config applies, so the first symbol already uses it.
  assign mode_eff = closed ? cfg_mode : mode_q;
  assign spp_eff  = closed ? cfg_spp  : spp_q;
  assign spp_lim  = (spp_eff == '0) ? '0 : spp_eff - 1'b1;
  assign hard     = (mode_eff == MODE_HARD);
  assign flush_go = cfg_flush & (~closed | sym);
  assign word_done = hard & sym & (pack_cnt == LAST_SYM);
  assign pack_pos = {~pack_cnt, 1'b0};

  always_comb begin
    pack_nxt = pack_q;
    if (sym) pack_nxt[pack_pos +: 2] = hard_bits(s_axis_tdata[DW-1], s_axis_tdata[IQ_W-1]);
    form      = (sym & ~hard) | word_done | flush_go;
    form_last = flush_go | (beat_cnt == spp_lim);
    form_data = '0;
    if (hard)     form_data[PACK_W-1:0] = pack_nxt;
    else if (sym) form_data = s_axis_tdata;
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      mode_q       <= MODE_SOFT;
      spp_q        <= '0;
      beat_cnt     <= '0;
      pack_cnt     <= '0;
      pack_q       <= '0;
      beat_vld     <= 1'b0;
      beat_last    <= 1'b0;
      beat_data    <= '0;
      overflow_cnt <= '0;
    end else begin
      if (closed) begin
        mode_q <= cfg_mode;
        spp_q  <= cfg_spp;
      end
      if (form) beat_cnt <= form_last ? '0 : beat_cnt + 1'b1;
      if (hard & sym & ~form) begin
        pack_q   <= pack_nxt;
        pack_cnt <= pack_cnt + 1'b1;
      end else if (form) begin
        pack_q   <= '0;
        pack_cnt <= '0;
      end
      beat_vld <= form;
      if (form) begin
        beat_data <= form_data;
        beat_last <= form_last;
      end
      // Drop is decided at the write stage; framing counters above are unaffected.
      if (beat_vld & fifo_full & ~&overflow_cnt) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  qpsk_sym_fifo #(.W(DW + 1), .AW(FIFO_AW)) u_fifo (
    .ce_clk   (ce_clk),
    .ce_rst   (ce_rst),
    .wr_en    (beat_vld),
    .wr_data  ({beat_last, beat_data}),
    .full     (fifo_full),
    .rd_data  ({m_axis_tlast, m_axis_tdata}),
    .rd_valid (m_axis_tvalid),
    .rd_ready (m_axis_tready),
    .level    (fifo_level)
  );
endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Self-checking bench for qpsk_symbol_framer: directed scenarios plus a randomized
// run against a packet-level reference model.
module tb_qpsk_symbol_framer;
  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, sym_stb, cfg_mode, cfg_flush;
  logic [11:0] cfg_spp;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [15:0] overflow_cnt;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int          m_beats, m_spp;
  logic        m_mode;
  logic [1:0]  m_hsyms[$];

  qpsk_symbol_framer #(.IQ_W(16), .FIFO_AW(2), .SPP_W(12)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .sym_stb(sym_stb), .cfg_mode(cfg_mode), .cfg_spp(cfg_spp), .cfg_flush(cfg_flush),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
  );

  always #5 ce_clk = ~ce_clk;

  // Output collector: a beat transfers at the next rising edge.
  always @(negedge ce_clk)
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});

  task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic f);
    s_axis_tvalid = v; sym_stb = s; s_axis_tdata = d; cfg_flush = f;
    @(posedge ce_clk); #1;
    s_axis_tvalid = 1'b0; sym_stb = 1'b0; cfg_flush = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge ce_clk);
    #1;
  endtask

  task automatic do_reset();
    ce_rst = 1'b1;
    s_axis_tvalid = 1'b0; sym_stb = 1'b0; cfg_flush = 1'b0; s_axis_tdata = '0;
    settle(2);
    ce_rst = 1'b0;
    got_q.delete();
  endtask

  // Reference model: packet-level rules on symbols and beats.
  task automatic emit(input logic [31:0] d, input logic force_last);
    logic l;
    l = force_last || (m_beats + 1 == m_spp);
    exp_q.push_back({l, d});
    m_beats = l ? 0 : m_beats + 1;
    m_hsyms.delete();
  endtask

  function automatic logic [31:0] packed_word();
    logic [31:0] w;
    w = '0;
    foreach (m_hsyms[i]) w = w | (32'(m_hsyms[i]) << (30 - 2 * i));
    return w;
  endfunction

  task automatic model_cycle(input logic v, input logic s, input logic [31:0] d, input logic f);
    logic sy;
    sy = v & s;
    if (m_beats == 0 && m_hsyms.size() == 0) begin
      m_mode = cfg_mode;
      m_spp  = (cfg_spp == 0) ? 1 : int'(cfg_spp);
    end
    if (!m_mode) begin
      if (sy) emit(d, f);
      else if (f && m_beats > 0) emit(32'h0, 1'b1);
    end else begin
      if (sy) m_hsyms.push_back({d[31], d[15]});
      if (m_hsyms.size() == 16) emit(packed_word(), f);
      else if (f && (m_beats > 0 || m_hsyms.size() > 0)) emit(packed_word(), 1'b1);
    end
  endtask

  task automatic test_reset();
    ce_rst = 1'b1; m_axis_tready = 1'b1; cfg_mode = 1'b0; cfg_spp = 12'd4;
    s_axis_tvalid = 1'b0; sym_stb = 1'b0; cfg_flush = 1'b0; s_axis_tdata = '0;
    settle(1);
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
    checks++; if (overflow_cnt !== 16'h0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    ce_rst = 1'b0; #1;
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL run_tready got=%b exp=1", s_axis_tready); end
  endtask

  task automatic test_soft_framing();
    int n;
    m_axis_tready = 1'b1; cfg_mode = 1'b0; cfg_spp = 12'd4;
    do_reset();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, (k % 4) == 3, 32'h0001_0002 + n, 1'b0);
      if ((k % 4) == 3) n++;
    end
    settle(5);
    checks++; if (got_q.size() != 10) begin failures++; $display("FAIL soft_count got=%0d exp=10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      logic [32:0] e;
      e = {(i == 3 || i == 7), 32'h0001_0002 + i};
      checks++; if (got_q[i] !== e) begin failures++; $display("FAIL soft_beat%0d got=%h exp=%h", i, got_q[i], e); end
    end
  endtask

  task automatic test_hard_packing();
    m_axis_tready = 1'b1; cfg_mode = 1'b1; cfg_spp = 12'd1;
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, (k % 2 == 0) ? 32'hFFFF_0001 : 32'h0001_FFFF, 1'b0);
    settle(5);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL hard_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== {1'b1, 32'h9999_9999}) begin
      failures++; $display("FAIL hard_beat got=%h exp=%h", got_q[0], {1'b1, 32'h9999_9999}); end
  endtask

  task automatic test_partial_flush();
    m_axis_tready = 1'b1; cfg_mode = 1'b1; cfg_spp = 12'd4;
    do_reset();
    repeat (3) cyc(1'b1, 1'b1, 32'h8000_8000, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL lat_edge0 got=%b exp=0", m_axis_tvalid); end
    settle(1);
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL lat_edge1 got=%b exp=0", m_axis_tvalid); end
    settle(1);
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL lat_edge2 got=%b exp=1", m_axis_tvalid); end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    settle(4);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== {1'b1, 32'hFC00_0000}) begin
      failures++; $display("FAIL flush_beat got=%h exp=%h", got_q[0], {1'b1, 32'hFC00_0000}); end
  endtask

  task automatic test_overflow();
    m_axis_tready = 1'b0; cfg_mode = 1'b0; cfg_spp = 12'd16;
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 32'h100 + k, 1'b0);
    settle(3);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow_cnt !== 16'd2) begin failures++; $display("FAIL ovf_cnt got=%0d exp=2", overflow_cnt); end
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 32'h100}) begin
      failures++; $display("FAIL ovf_hold got=%b/%b/%h exp=1/0/00000100", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
    m_axis_tready = 1'b1;
    settle(6);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== {1'b0, 32'h100 + i}) begin
        failures++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, got_q[i], {1'b0, 32'h100 + i}); end
    end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL ovf_empty got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_flush_sym();
    m_axis_tready = 1'b1; cfg_mode = 1'b0; cfg_spp = 12'd8;
    do_reset();
    cyc(1'b1, 1'b1, 32'hA000_0000, 1'b0);
    cyc(1'b1, 1'b1, 32'hA000_0001, 1'b0);
    cyc(1'b1, 1'b1, 32'hA000_0002, 1'b1);
    cyc(1'b1, 1'b1, 32'hA000_0003, 1'b0);
    cfg_spp = 12'd2;
    for (int k = 4; k < 13; k++) cyc(1'b1, 1'b1, 32'hA000_0000 + k, 1'b0);
    settle(5);
    checks++; if (got_q.size() != 13) begin failures++; $display("FAIL fs_count got=%0d exp=13", got_q.size()); end
    for (int i = 0; i < 13 && i < got_q.size(); i++) begin
      logic [32:0] e;
      e = {(i == 2 || i == 10 || i == 12), 32'hA000_0000 + i};
      checks++; if (got_q[i] !== e) begin failures++; $display("FAIL fs_beat%0d got=%h exp=%h", i, got_q[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b0; cfg_mode = 1'b0; cfg_spp = 12'd16;
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 32'h55 + k, 1'b0);
    settle(3);
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL rm_level_pre got=%0d exp=3", fifo_level); end
    ce_rst = 1'b1; #1;
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'h0) begin
      failures++; $display("FAIL rm_out got=%b/%b/%h exp=0/0/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", fifo_level); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rm_tready got=%b exp=0", s_axis_tready); end
    settle(1);
    ce_rst = 1'b0; got_q.delete(); m_axis_tready = 1'b1; cfg_spp = 12'd2;
    cyc(1'b1, 1'b1, 32'hC0DE_0001, 1'b0);
    cyc(1'b1, 1'b1, 32'hC0DE_0002, 1'b0);
    settle(5);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rm_count got=%0d exp=2", got_q.size()); end
    checks++; if (got_q.size() == 2 && (got_q[0] !== {1'b0, 32'hC0DE_0001} || got_q[1] !== {1'b1, 32'hC0DE_0002})) begin
      failures++; $display("FAIL rm_pkt got=%h,%h exp=%h,%h", got_q[0], got_q[1], {1'b0, 32'hC0DE_0001}, {1'b1, 32'hC0DE_0002}); end
  endtask

  task automatic test_random();
    logic v, s, f;
    logic [31:0] d;
    m_axis_tready = 1'b1; cfg_mode = 1'b0; cfg_spp = 12'd3;
    do_reset();
    exp_q.delete(); m_hsyms.delete(); m_beats = 0; m_spp = 1; m_mode = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3) cfg_mode = ~cfg_mode;
      if ($urandom_range(0, 99) < 3) cfg_spp = 12'($urandom_range(0, 5));
      v = ($urandom_range(0, 99) < 80);
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 2);
      d = $urandom;
      model_cycle(v, s, d, f);
      cyc(v, s, d, f);
    end
    settle(6);
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow_cnt !== 16'h0) begin failures++; $display("FAIL rnd_ovf got=%0d exp=0", overflow_cnt); end
  endtask

  initial begin
    test_reset();
    test_soft_framing();
    test_hard_packing();
    test_partial_flush();
    test_overflow();
    test_flush_sym();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qpsk_symbol_framer.md
# qpsk_symbol_framer

Parametrised symbol-rate framer for the QPSK receive chain, sitting between the carrier/bit-sync stage and the AXI wrapper's output stream. It captures only the input beats flagged by the symbol strobe and buffers them in a FIFO. In soft mode it emits raw IQ symbols; in hard mode it emits packed 2-bit decisions. Packets are re-framed to a programmable length with a proper tlast, and symbols are never stalled upstream: overflow drops and counts.

## Interface
- IQ_W, 16, bits per I and per Q component; must be ≥16.
- FIFO_AW, 5, FIFO address width; depth 2^FIFO_AW.
- SPP_W, 12, width of the beats-per-packet setting.

- ce_clk  in  1  clock.
- ce_rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  2*IQ_W  sample, {I, Q}, both signed.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  0 in reset, constant 1 otherwise.
- sym_stb  in  1  beat is a symbol centre; qualified by s_axis_tvalid.
- cfg_mode  in  1  0 = soft IQ, 1 = hard packed.
- cfg_spp  in  SPP_W  output beats per packet; 0 treated as 1.
- cfg_flush  in  1  one-cycle strobe that closes the open packet.
- m_axis_tdata  out  2*IQ_W  output beat.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- overflow_cnt  out  16  symbols dropped on FIFO full; saturating.
- fifo_level  out  FIFO_AW+1  entries held.

## Operation
- A symbol is taken when `s_axis_tvalid & sym_stb`. Beats without the strobe are consumed and discarded.
- **Soft mode:** each symbol forms one output beat equal to the input {I, Q}.
- **Hard mode:** each symbol yields bits {I[msb], Q[msb]}, where 1 means negative.
  - 16 symbols pack into tdata[31:0], first symbol in [31:30]. Upper bits are zero.
  - A beat is formed on the 16th symbol.
- **Beat counter:** increments per formed beat. The beat at count == cfg_spp-1 carries last=1, and the counter returns to 0.
- **Flush:** if a packet is open (beat count > 0 or a partial pack word exists), cfg_flush forms one beat with last=1 and resets both counters.
  - Hard mode: the beat is the partial word, zero-padded.
  - Soft mode with no partial word: the beat carries the symbol arriving that cycle if present, otherwise zero data.
  - Flush with no open packet is ignored.
- **Flush and symbol in the same cycle:** the symbol is included in the flushed beat first. At most one FIFO write occurs per cycle.
- **Config latching:** cfg_mode and cfg_spp are latched only when the packet is closed (both counters 0). Changes mid-packet take effect at the next packet.
- **Overflow:** a beat formed while the FIFO is full is dropped and overflow_cnt increments, saturating at 0xFFFF. Counters still advance, so framing stays aligned to symbol count.

## Timing
- Formed beat is registered, then written to the FIFO.
- m_axis_tvalid rises 2 cycles after the accepting edge when the FIFO was empty.
- Output handshake: standard AXI-stream. tdata and tlast are held stable while `tvalid & ~tready`.
- A FIFO write and read in the same cycle leave fifo_level unchanged. A write while full is dropped even if a read occurs in that cycle.
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, s_axis_tready = 0, overflow_cnt = 0, fifo_level = 0. Pack register and counters are cleared.
- Reset asserted mid-packet discards FIFO contents and the partial word. No tlast is emitted for the aborted packet.
- Throughput: one symbol per cycle sustained while m_axis_tready = 1.

## Structure
- Package `qpsk_pkg`:
  - MODE_SOFT = 1'b0, MODE_HARD = 1'b1.
  - SYMS_PER_WORD = 16.
  - Function for the hard-decision bit pair.
- Sub-module `qpsk_sym_fifo`:
  - Synchronous FIFO of width 2*IQ_W+1 ({last, data}) and depth 2^FIFO_AW.
  - Registered output, level output, first-word fall-through on the AXI side.
- Top level holds the strobe qualifier, pack shift register, beat counter, flush logic, config latch and overflow counter.

## Test plan
- **Soft framing:** soft mode, cfg_spp=4, 10 symbols 0x00010002…, strobe on every 4th input beat → two 4-beat packets with tlast on beats 4 and 8, and 2 beats buffered with no tlast.
- **Hard packing:** hard mode, cfg_spp=1, 16 symbols alternating I=-1,Q=+1 / I=+1,Q=-1 → one beat 0x99999999 with tlast=1.
- **Partial flush:** hard mode, 3 symbols all negative, then cfg_flush → one beat 0xFC000000 with tlast=1. A second flush alone produces no beat.
- **Overflow:** FIFO_AW=2, m_axis_tready=0, 6 soft symbols → fifo_level=4, overflow_cnt=2. Releasing ready yields the first 4 symbols in order.
- **Simultaneous flush and symbol:** soft mode, cfg_spp=8, 2 symbols, then a symbol with cfg_flush in the same cycle → 3-beat packet, tlast on beat 3. A cfg_spp change mid-packet applies only to the following packet.
- **Reset mid-operation:** ce_rst asserted with 3 entries queued → all outputs 0 immediately. After release, a fresh packet starts with count 0.
